rom_stream_reader: RTL and testbench
====================================

// Module: rom_stream_reader
// PURPOSE
//  Read-side companion to the byte-loader ROM: a 2^ADDR_W x DATA_W byte store written by random
//  address, drained as a sequential burst over a valid/ready stream.
//  Feeds the output pins/downstream consumers.
//  A burst is a start address and a length. Addresses wrap modulo 2^ADDR_W.
// PARAMETERS
//  ADDR_W  8  address width; depth = 2^ADDR_W entries
//  DATA_W  8  data width of each entry and of the stream
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  ena         in   1       design enable; low freezes all state (FSM, pointers, writes)
//  wr_en       in   1       write strobe
//  wr_addr     in   ADDR_W  write address
//  wr_data     in   DATA_W  write data
//  start       in   1       burst request, sampled in IDLE only
//  start_addr  in   ADDR_W  first address of burst (latched on accepted start)
//  length      in   ADDR_W  beats in burst; 0 means 2^ADDR_W beats
//  out_valid   out  1       stream data valid
//  out_ready   in   1       consumer ready
//  out_data    out  DATA_W  stream data
//  out_last    out  1       qualifies final beat of burst
//  busy        out  1       high in any state other than IDLE
//  done        out  1       one-cycle pulse after final beat handshakes
// BEHAVIOUR
//  Reset: FSM=IDLE; out_valid, out_last, busy, done = 0; out_data = 0; ptr and remaining count = 0.
//   Memory array is not reset.
//  Memory: synchronous write; synchronous read (1 cycle). Write and read on the same address in the
//   same cycle return the OLD data. Writes are accepted in every state while ena=1.
//  FSM (advances only when ena=1):
//   IDLE  -> FETCH on start=1: ptr<=start_addr, rem<=length (0 loads 2^ADDR_W, ADDR_W+1 bits).
//   FETCH -> SEND: issue read of mem[ptr]; next cycle out_data=mem[ptr], out_valid=1,
//            out_last=(rem==1).
//   SEND: hold out_valid/out_data/out_last stable until out_ready=1 (valid never drops
//         without handshake).
//     On handshake with rem>1: ptr<=ptr+1 (wraps), rem<=rem-1, out_valid<=0, -> FETCH.
//     On handshake with rem==1: out_valid<=0, out_last<=0, -> DONE.
//   DONE  -> IDLE, done=1 for this cycle only. start in DONE is ignored.
//  Throughput: one beat per 2 cycles with out_ready held high.
//   Latency start -> first out_valid = 2 cycles.
//  start while busy: ignored (no restart, no queueing).
//  ena=0 mid-burst: all registers hold; out_valid stays asserted if it was, a handshake with
//   ena=0 does not count.
//  Async reset mid-burst: immediate return to reset values; burst abandoned, no done pulse.
//  Wrap: start_addr=2^ADDR_W-1, length=2 streams mem[2^ADDR_W-1], mem[0].
// CONFIGURATION
//  ROM_STREAM_CHECKSUM_EN defined: adds output checksum [DATA_W-1:0].
//   Cleared to 0 on accepted start and on reset; XOR-accumulates out_data on every handshake.
//   Final value is valid while done=1 and held until the next start.
//  Not defined: no checksum port, no accumulator logic.
// TESTING
//  1 Write mem[i]=i^8'hA5 for i=0..255; start_addr=0x10, length=4, out_ready=1
//    -> beats 0xB5,0xB4,0xB7,0xB6; out_last only on beat 4; done 1 cycle after.
//  2 Backpressure: length=3, out_ready toggles 0/1 randomly
//    -> out_data/out_valid/out_last never change while valid&&!ready; exactly 3 handshakes.
//  3 Wrap and full burst: start_addr=0xFF, length=2 -> 0x5A, 0xA5.
//    Then length=0 from 0x00 -> 256 beats; last beat data=0x5A with out_last.
//  4 Hazards: write mem[ptr]=0x00 in the FETCH cycle -> old value streamed.
//    start pulsed while busy -> ignored, burst completes normally.
//  5 ena=0 for 5 cycles mid-SEND with out_ready=1 -> no progress, outputs frozen;
//    resumes on ena=1. rst_n low mid-burst -> out_valid=0, busy=0 asynchronously, no done.
//  6 With ROM_STREAM_CHECKSUM_EN: burst of test 1 -> checksum=0xB5^0xB4^0xB7^0xB6=0x00.
//    Burst 0x10, length=3 -> 0xB6.

Source files
------------

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
// Byte store written by random address and drained as a sequential burst
// over a valid/ready stream. A burst is a start address plus a length.
// A length of 0 means a full 2^ADDR_W-beat burst. Addresses wrap modulo 2^ADDR_W.
// Optional feature: define ROM_STREAM_CHECKSUM_EN to add an XOR checksum output
// over the streamed beats.
module rom_stream_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
`ifdef ROM_STREAM_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   rem;
   logic              handshake;
   logic              last_beat;
   logic              accept_start;

   // Only a transfer seen while enabled counts, so a frozen handshake cannot advance the burst.
   assign handshake    = (state == SEND) && out_valid && out_ready;
   assign last_beat    = (rem == {{ADDR_W{1'b0}}, 1'b1});
   assign accept_start = (state == IDLE) && start;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

   // Write port. A read of the same entry in the same cycle sees the old contents.
   always_ff @(posedge clk) begin
      if (ena && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // State register. It advances only while the block is enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A start that arrives outside IDLE is ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   state_nxt = SEND;
         SEND:    if (handshake) state_nxt = last_beat ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Burst datapath: pointer, remaining-beat count and the registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (start) begin
                  ptr <= start_addr;
                  rem <= (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, length};
               end
            end
            FETCH: begin
               out_data  <= mem[ptr];
               out_valid <= 1'b1;
               out_last  <= last_beat;
            end
            SEND: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (!last_beat) begin
                     ptr <= ptr + 1'b1;
                     rem <= rem - 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef ROM_STREAM_CHECKSUM_EN
   // XOR checksum over the beats of the current burst. It is cleared when a burst starts
   // and keeps its final value until the next burst starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (ena) begin
         if (accept_start) begin
            checksum <= '0;
         end else if (handshake) begin
            checksum <= checksum ^ out_data;
         end
      end
   end
`else
   // accept_start is needed only by the checksum. Referencing it here keeps it from being unused.
   logic unused_start;
   assign unused_start = accept_start;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
// Directed self-checking bench for rom_stream_reader.
// It keeps its own copy of the memory contents and uses that copy to predict every beat.
module tb_rom_stream_reader;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       start;
   logic [7:0] start_addr;
   logic [7:0] length;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       done;
`ifdef ROM_STREAM_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   logic [7:0] tbMem [256];
   int         checkCount;
   int         failCount;

   rom_stream_reader #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .start_addr (start_addr),
      .length     (length),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
`ifdef ROM_STREAM_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog. It stops a runaway simulation.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it if the observed value differs from the expected value.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Writes one memory entry. It is called on a falling edge and returns on the next falling edge.
   task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      @(posedge clk);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Runs one burst and checks every beat, stall stability, the out_last position and the done pulse.
   // hazard:      writes 0 to the first address in the FETCH cycle and pulses start while busy.
   // randomReady: toggles out_ready at random.
   task automatic runBurst(input logic [7:0] sa, input logic [7:0] len,
                           input bit randomReady, input bit hazard);
      int         expBeats;
      int         beats;
      int         cycles;
      logic [7:0] addr;
      logic [7:0] prevData;
      logic [7:0] csModel;
      logic       prevStall;
      logic       prevLast;
      expBeats  = (len == 8'd0) ? 256 : int'(len);
      beats     = 0;
      cycles    = 0;
      addr      = sa;
      prevData  = 8'h00;
      prevLast  = 1'b0;
      prevStall = 1'b0;
      csModel   = 8'h00;
      start      = 1'b1;
      start_addr = sa;
      length     = len;
      out_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", busy, 1);
      while (beats < expBeats && cycles < 4 * expBeats + 8) begin
         if (hazard && cycles == 0) begin
            wr_en   = 1'b1;
            wr_addr = sa;
            wr_data = 8'h00;
         end else begin
            wr_en = 1'b0;
         end
         if (hazard && cycles == 1) begin
            start      = 1'b1;
            start_addr = sa + 8'h40;
            length     = 8'd9;
         end else begin
            start = 1'b0;
         end
         out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!randomReady) checkOutput("valid_cadence", out_valid, (cycles % 2) == 1);
         if (prevStall) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data", out_data, prevData);
            checkOutput("stall_last", out_last, prevLast);
         end
         if (out_valid && out_ready) begin
            checkOutput("beat_data", out_data, tbMem[addr]);
            checkOutput("beat_last", out_last, beats == expBeats - 1);
            csModel = csModel ^ tbMem[addr];
            beats++;
            addr = addr + 8'd1;
         end
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
         prevLast  = out_last;
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end
      wr_en = 1'b0;
      start = 1'b0;
      if (hazard) tbMem[sa] = 8'h00;
      checkOutput("beat_count", beats, expBeats);
      checkOutput("done_pulse", done, 1);
      checkOutput("done_valid_low", out_valid, 0);
      checkOutput("done_last_low", out_last, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
      checkOutput("checksum_done", checksum, csModel);
`endif
      start      = 1'b1;
      start_addr = 8'h33;
      length     = 8'd1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("done_cleared", done, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_valid", out_valid, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
      checkOutput("checksum_held", checksum, csModel);
`endif
   endtask

   // Main sequence.
   initial begin
      checkCount = 0;
      failCount  = 0;
      rst_n      = 1'b0;
      ena        = 1'b1;
      wr_en      = 1'b0;
      wr_addr    = 8'h00;
      wr_data    = 8'h00;
      start      = 1'b0;
      start_addr = 8'h00;
      length     = 8'h00;
      out_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_last", out_last, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_data", out_data, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
      checkOutput("reset_checksum", checksum, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 256; i++) begin
         tbMem[i] = 8'(i) ^ 8'hA5;
         applyStimulus(8'(i), 8'(i) ^ 8'hA5);
      end

      // Basic burst: the beats should be B5, B4, B7, B6.
      runBurst(8'h10, 8'd4, 1'b0, 1'b0);
`ifdef ROM_STREAM_CHECKSUM_EN
      checkOutput("checksum_const4", checksum, 8'h00);
`endif
      // Backpressure.
      runBurst(8'h80, 8'd3, 1'b1, 1'b0);
      runBurst(8'h81, 8'd5, 1'b1, 1'b0);
      // Wrap, then a full 256-beat burst.
      runBurst(8'hFF, 8'd2, 1'b0, 1'b0);
      runBurst(8'h00, 8'd0, 1'b0, 1'b0);
      // Read/write hazard and a start while busy. The follow-up burst shows that the write landed.
      runBurst(8'h30, 8'd2, 1'b0, 1'b1);
      runBurst(8'h30, 8'd1, 1'b0, 1'b0);
`ifdef ROM_STREAM_CHECKSUM_EN
      runBurst(8'h10, 8'd3, 1'b0, 1'b0);
      checkOutput("checksum_const3", checksum, 8'hB6);
`endif

      // Hold ena low mid-SEND. A write attempted while disabled must be dropped.
      start      = 1'b1;
      start_addr = 8'h20;
      length     = 8'd2;
      out_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("ena_pre_valid", out_valid, 1);
      ena     = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 8'h21;
      wr_data = 8'hEE;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("ena_hold_valid", out_valid, 1);
         checkOutput("ena_hold_data", out_data, tbMem[8'h20]);
         checkOutput("ena_hold_busy", busy, 1);
         checkOutput("ena_hold_done", done, 0);
      end
      wr_en = 1'b0;
      ena   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("ena_resume_fetch", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("ena_beat2_data", out_data, tbMem[8'h21]);
      checkOutput("ena_beat2_last", out_last, 1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("ena_done", done, 1);
      @(posedge clk);
      @(negedge clk);

      // Asynchronous reset mid-burst.
      out_ready  = 1'b0;
      start      = 1'b1;
      start_addr = 8'h50;
      length     = 8'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_pre_valid", out_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_valid", out_valid, 0);
      checkOutput("rst_async_busy", busy, 0);
      checkOutput("rst_async_data", out_data, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("rst_no_done", done, 0);
         checkOutput("rst_stay_idle", busy, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
